// File: rtl/instruction_fetch_if.sv
// Load, start, ready and instruction-presentation signals of instruction_fetch.
// The slave modport faces the fetch unit; the master modport faces its driver.
interface instruction_fetch_if #(
    parameter int DEPTH       = 16,
    parameter int INSTR_WIDTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                   i_load_en;
    logic [AW-1:0]          i_load_addr;
    logic [INSTR_WIDTH-1:0] i_load_data;
    logic                   i_start;
    logic                   i_ready;
    logic [INSTR_WIDTH-1:0] o_instruction;
    logic                   o_valid;
    logic [AW-1:0]          o_pc;
    logic                   o_busy;
    logic                   o_done;

    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_start, i_ready,
        output o_instruction, o_valid, o_pc, o_busy, o_done
    );

    modport master (
        output i_load_en, i_load_addr, i_load_data, i_start, i_ready,
        input  o_instruction, o_valid, o_pc, o_busy, o_done
    );
endinterface

// File: rtl/instruction_fetch.sv
// Program store plus fetch FSM: o_valid two edges after start, one word per 2 cycles, held until i_ready.
// Define INSTR_FETCH_WRAP_EN to loop from the last word back to address 0 instead of stopping.
module instruction_fetch #(
    parameter int DEPTH       = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    instruction_fetch_if.slave   bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        FETCH   = 4'b0010,
        PRESENT = 4'b0100,
        DONE    = 4'b1000
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] rd_word;
    logic                   load_window;
    logic                   mem_we;

    assign rd_word     = mem_q[pc_q];
    assign load_window = (state_q == IDLE) || (state_q == DONE);
    assign mem_we      = !i_reset && load_window && bus.i_load_en;

    // Program storage survives reset so a program can be rerun after a reset.
    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem_q[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A load in the same cycle as start takes precedence.
                if (bus.i_start && !bus.i_load_en) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                if (rd_word != '0) begin
                    instr_d = rd_word;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end else begin
                    state_d = DONE;
                end
            end
            PRESENT: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    if (pc_q != LAST) begin
                        pc_d    = pc_q + 1'b1;
                        state_d = FETCH;
                    end else begin
`ifdef INSTR_FETCH_WRAP_EN
                        pc_d    = '0;
                        state_d = FETCH;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                instr_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_busy        = (state_q == FETCH) || (state_q == PRESENT);
    assign bus.o_done        = (state_q == DONE);
endmodule
